// File: rtl/g2b_pkg.sv
// Shared types and helpers for the Grey-to-binary tracker.
package g2b_pkg;

   localparam int unsigned G2B_WIDTH = 4;
   localparam int unsigned G2B_MAX_W = 32;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DOWN,
      STEP_ERR
   } step_e;

   typedef enum logic {
      INIT,
      TRACK
   } state_e;

   // Grey to binary over the widest supported code; zero upper bits leave the low bits exact.
   function automatic logic [G2B_MAX_W-1:0] grey_to_bin(input logic [G2B_MAX_W-1:0] g);
      logic [G2B_MAX_W-1:0] b;
      b = g;
      for (int i = int'(G2B_MAX_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/g2b_debounce.sv
// Two-flop synchroniser plus stability filter; commit_c strobes once per stable period.
module g2b_debounce
   import g2b_pkg::*;
#(
   parameter int unsigned WIDTH         = G2B_WIDTH,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] grey_in,
   output logic [WIDTH-1:0] cand,
   output logic             commit_c
);

   localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: shift synchroniser, restart count on change, otherwise count up and saturate.
   always_comb begin
      s1_d   = grey_in;
      s2_d   = s1_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

   assign commit_c = (s2_q == cand_q) && (cnt_q == CNT_LAST);
   assign cand     = cand_q;

endmodule

// File: rtl/grey2bin_tracker.sv
// Grey-coded position tracker: debounce, convert, classify steps, accumulate position.
// Define G2B_SKIP_COMP_EN to accept +/-2 jumps as double steps instead of errors.
module grey2bin_tracker
   import g2b_pkg::*;
#(
   parameter int unsigned WIDTH         = G2B_WIDTH,
   parameter int unsigned STABLE_CYCLES = 3,
   parameter int unsigned POS_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     grey_input,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     binary_output,
   output logic                 valid,
   output logic                 step_up,
   output logic                 step_down,
   output logic [POS_WIDTH-1:0] position,
   output logic                 error
);

   localparam logic [WIDTH-1:0] D_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] D_MONE = '1;
`ifdef G2B_SKIP_COMP_EN
   localparam logic [WIDTH-1:0] D_TWO  = WIDTH'(2);
   localparam logic [WIDTH-1:0] D_MTWO = ~WIDTH'(1);
`endif

   logic [WIDTH-1:0]     cand;
   logic                 commit_c;
   logic [WIDTH-1:0]     bin_c;
   logic [WIDTH-1:0]     delta_c;
   step_e                step_c;
   logic [POS_WIDTH-1:0] step_amt_c;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     binary_q, binary_d;
   logic                 valid_q, valid_d;
   logic                 step_up_q, step_up_d;
   logic                 step_down_q, step_down_d;
   logic [POS_WIDTH-1:0] pos_q, pos_d;
   logic                 error_q, error_d;

   g2b_debounce #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .grey_in  (grey_input),
      .cand     (cand),
      .commit_c (commit_c)
   );

   assign bin_c = WIDTH'(grey_to_bin(G2B_MAX_W'(cand)));

   // Classify the modular difference between the candidate and the last accepted value.
   always_comb begin
      delta_c    = bin_c - binary_q;
      step_c     = STEP_ERR;
      step_amt_c = POS_WIDTH'(1);
      if (delta_c == '0) begin
         step_c = STEP_NONE;
      end else if (delta_c == D_ONE) begin
         step_c = STEP_UP;
      end else if (delta_c == D_MONE) begin
         step_c = STEP_DOWN;
`ifdef G2B_SKIP_COMP_EN
      end else if (delta_c == D_TWO) begin
         step_c     = STEP_UP;
         step_amt_c = POS_WIDTH'(2);
      end else if (delta_c == D_MTWO) begin
         step_c     = STEP_DOWN;
         step_amt_c = POS_WIDTH'(2);
`endif
      end
   end

   // FSM next-state and output logic; pulses default low, error clears unless re-set.
   always_comb begin
      state_d     = state_q;
      binary_d    = binary_q;
      valid_d     = valid_q;
      step_up_d   = 1'b0;
      step_down_d = 1'b0;
      pos_d       = pos_q;
      error_d     = error_q & ~err_clr;
      if (commit_c) begin
         case (state_q)
            INIT: begin
               binary_d = bin_c;
               valid_d  = 1'b1;
               state_d  = TRACK;
            end
            TRACK: begin
               case (step_c)
                  STEP_UP: begin
                     step_up_d = 1'b1;
                     pos_d     = pos_q + step_amt_c;
                     binary_d  = bin_c;
                  end
                  STEP_DOWN: begin
                     step_down_d = 1'b1;
                     pos_d       = pos_q - step_amt_c;
                     binary_d    = bin_c;
                  end
                  STEP_ERR: begin
                     error_d  = 1'b1;
                     binary_d = bin_c;
                  end
                  default: begin
                  end
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         binary_q    <= '0;
         valid_q     <= 1'b0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         pos_q       <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         binary_q    <= binary_d;
         valid_q     <= valid_d;
         step_up_q   <= step_up_d;
         step_down_q <= step_down_d;
         pos_q       <= pos_d;
         error_q     <= error_d;
      end
   end

   assign binary_output = binary_q;
   assign valid         = valid_q;
   assign step_up       = step_up_q;
   assign step_down     = step_down_q;
   assign position      = pos_q;
   assign error         = error_q;

endmodule

// File: tb/tb_grey2bin_tracker.sv
// Scoreboard bench for grey2bin_tracker; expected results come from a spec-level model.
module tb_grey2bin_tracker;

   localparam int unsigned SC = 3;

   logic        clk;
   logic        rst;
   logic [3:0]  grey_input;
   logic        err_clr;
   logic [3:0]  binary_output;
   logic        valid;
   logic        step_up;
   logic        step_down;
   logic [15:0] position;
   logic        error;

   typedef struct packed {
      logic [3:0]  bin;
      logic [15:0] pos;
      logic        up;
      logic        down;
      logic        err;
      logic        valid;
   } obs_t;

   obs_t obs;
   obs_t e;
   obs_t pre;
   obs_t exp_q[$];

   logic [3:0]  m_bin;
   logic [15:0] m_pos;
   logic        m_err;
   logic        m_valid;

   int checks   = 0;
   int failures = 0;

   assign obs = {binary_output, position, step_up, step_down, error, valid};

   grey2bin_tracker #(
      .WIDTH         (4),
      .STABLE_CYCLES (SC),
      .POS_WIDTH     (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .grey_input    (grey_input),
      .err_clr       (err_clr),
      .binary_output (binary_output),
      .valid         (valid),
      .step_up       (step_up),
      .step_down     (step_down),
      .position      (position),
      .error         (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] to_grey(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic obs_t model_obs();
      return {m_bin, m_pos, 1'b0, 1'b0, m_err, m_valid};
   endfunction

   task automatic model_reset();
      m_bin   = 4'd0;
      m_pos   = 16'd0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
   endtask

   // Model one accepted sample and push the expected post-commit outputs.
   task automatic model_commit(input logic [3:0] nb);
      logic [3:0] d;
      logic       up;
      logic       dn;
      up = 1'b0;
      dn = 1'b0;
      if (!m_valid) begin
         m_valid = 1'b1;
         m_bin   = nb;
      end else begin
         d = nb - m_bin;
         if (d == 4'd1) begin
            up = 1'b1; m_pos = m_pos + 16'd1; m_bin = nb;
         end else if (d == 4'd15) begin
            dn = 1'b1; m_pos = m_pos - 16'd1; m_bin = nb;
`ifdef G2B_SKIP_COMP_EN
         end else if (d == 4'd2) begin
            up = 1'b1; m_pos = m_pos + 16'd2; m_bin = nb;
         end else if (d == 4'd14) begin
            dn = 1'b1; m_pos = m_pos - 16'd2; m_bin = nb;
`endif
         end else if (d != 4'd0) begin
            m_err = 1'b1; m_bin = nb;
         end
      end
      exp_q.push_back({m_bin, m_pos, up, dn, m_err, m_valid});
   endtask

   // Drive a binary value as Grey and advance to just after edge STABLE_CYCLES+2.
   task automatic drive_bin(input logic [3:0] b);
      grey_input = to_grey(b);
      model_commit(b);
      repeat (SC + 2) tick();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      err_clr    = 1'b0;
      grey_input = to_grey(4'd3);
      model_reset();
      repeat (3) tick();
      checks++;
      if (obs !== model_obs()) begin
         failures++;
         $display("FAIL reset_state: got %h want %h", obs, model_obs());
      end
   endtask

   task automatic test_init();
      rst = 1'b0;
      pre = model_obs();
      drive_bin(4'd3);
      checks++;
      if (obs !== pre) begin
         failures++;
         $display("FAIL init_latency: got %h want %h", obs, pre);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL init_commit: got %h want %h", obs, e);
      end
      tick();
      checks++;
      if (obs !== model_obs()) begin
         failures++;
         $display("FAIL init_settle: got %h want %h", obs, model_obs());
      end
   endtask

   task automatic test_step_up();
      pre = model_obs();
      drive_bin(4'd4);
      checks++;
      if (obs !== pre) begin
         failures++;
         $display("FAIL step_up_hold: got %h want %h", obs, pre);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL step_up_commit: got %h want %h", obs, e);
      end
      tick();
      checks++;
      if (obs !== model_obs()) begin
         failures++;
         $display("FAIL step_up_one_cycle: got %h want %h", obs, model_obs());
      end
   endtask

   task automatic test_glitch();
      grey_input = to_grey(4'd5);
      tick();
      tick();
      grey_input = to_grey(4'd4);
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (obs !== model_obs()) begin
            failures++;
            $display("FAIL glitch[%0d]: got %h want %h", i, obs, model_obs());
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] seq [13];
      for (int i = 0; i < 11; i++) seq[i] = 4'(i + 5);
      seq[11] = 4'd0;
      seq[12] = 4'd15;
      for (int i = 0; i < 13; i++) begin
         pre = model_obs();
         drive_bin(seq[i]);
         checks++;
         if (obs !== pre) begin
            failures++;
            $display("FAIL wrap_hold[%0d]: got %h want %h", i, obs, pre);
         end
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL wrap_commit[%0d]: got %h want %h", i, obs, e);
         end
         tick();
         checks++;
         if (obs !== model_obs()) begin
            failures++;
            $display("FAIL wrap_settle[%0d]: got %h want %h", i, obs, model_obs());
         end
      end
   endtask

   task automatic test_jump();
      logic [3:0] seq [5];
      logic       clr_at_commit [5];
      logic       clr_after [5];
      seq = '{4'd3, 4'd6, 4'd3, 4'd5, 4'd3};
      clr_at_commit = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      clr_after     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         pre = model_obs();
         drive_bin(seq[i]);
         checks++;
         if (obs !== pre) begin
            failures++;
            $display("FAIL jump_hold[%0d]: got %h want %h", i, obs, pre);
         end
         err_clr = clr_at_commit[i];
         tick();
         err_clr = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL jump_commit[%0d]: got %h want %h", i, obs, e);
         end
         tick();
         checks++;
         if (obs !== model_obs()) begin
            failures++;
            $display("FAIL jump_settle[%0d]: got %h want %h", i, obs, model_obs());
         end
         if (clr_after[i]) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            m_err   = 1'b0;
            checks++;
            if (obs !== model_obs()) begin
               failures++;
               $display("FAIL err_clr[%0d]: got %h want %h", i, obs, model_obs());
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20 && m_pos != 16'd5; i++) begin
         pre = model_obs();
         drive_bin(m_bin - 4'd1);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reach_pos[%0d]: got %h want %h", i, obs, e);
         end
         tick();
      end
      checks++;
      if (position !== 16'd5) begin
         failures++;
         $display("FAIL reach_pos_final: got %0d want 5", position);
      end
      grey_input = to_grey(4'd9);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs !== model_obs()) begin
         failures++;
         $display("FAIL mid_reset: got %h want %h", obs, model_obs());
      end
      grey_input = to_grey(4'd2);
      repeat (2) tick();
      rst = 1'b0;
      pre = model_obs();
      drive_bin(4'd2);
      checks++;
      if (obs !== pre) begin
         failures++;
         $display("FAIL reinit_hold: got %h want %h", obs, pre);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL reinit_commit: got %h want %h", obs, e);
      end
   endtask

   initial begin
      rst        = 1'b1;
      err_clr    = 1'b0;
      grey_input = 4'd0;
      #2;
      test_reset();
      test_init();
      test_step_up();
      test_glitch();
      test_wrap();
      test_jump();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
